// File: rtl/general_register_file_if.sv
// ---------------------------------------------------------------------------
// general_register_file_if
//   Bus between the register file and whoever drives it (controller / ALU
//   path). Carries write data, function/select controls and the two
//   combinational read ports.
//   master : drives i_data, fun_sel, reg_sel, scr_sel, out_a_sel, out_b_sel;
//            receives out_a, out_b
//   slave  : the register file itself
// ---------------------------------------------------------------------------
interface general_register_file_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] i_data;     // write data (ALUOut or memory/IR path)
  logic [2:0]       fun_sel;    // function applied to every enabled register
  logic [3:0]       reg_sel;    // write enables R1..R4 (bit0 = R1)
  logic [3:0]       scr_sel;    // write enables S1..S4 (bit0 = S1)
  logic [2:0]       out_a_sel;  // 0-3 = R1-R4, 4-7 = S1-S4
  logic [2:0]       out_b_sel;
  logic [WIDTH-1:0] out_a;      // ALU operand A
  logic [WIDTH-1:0] out_b;      // ALU operand B

  modport master (
    output i_data, fun_sel, reg_sel, scr_sel, out_a_sel, out_b_sel,
    input  out_a, out_b
  );

  modport slave (
    input  i_data, fun_sel, reg_sel, scr_sel, out_a_sel, out_b_sel,
    output out_a, out_b
  );
endinterface

// File: rtl/general_register_file.sv
// ---------------------------------------------------------------------------
// general_register_file
//   Four general (R1-R4) and four scratch (S1-S4) registers feeding the ALU.
//   Every register whose enable bit is set applies the same function on the
//   rising clock edge; unselected registers hold. Reads are a purely
//   combinational mux with no write-through bypass.
//   Ports:
//     clk_i  : clock, all updates on posedge
//     rst_i  : asynchronous active-high reset, loads RESET_VALUE everywhere
//     rf_if  : slave side of general_register_file_if (data, selects, OutA/B)
// ---------------------------------------------------------------------------
module general_register_file #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  general_register_file_if.slave rf_if
);

  typedef enum logic [2:0] {
    FUN_DEC   = 3'b000,
    FUN_INC   = 3'b001,
    FUN_LOAD  = 3'b010,
    FUN_CLEAR = 3'b011,
    FUN_LDLZ  = 3'b100,
    FUN_LDL   = 3'b101,
    FUN_LDH   = 3'b110,
    FUN_LDSX  = 3'b111
  } fun_e;

  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(8'hFF);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic [7:0]       wr_en;

  // Index order matches the read select encoding: 0-3 = R1-R4, 4-7 = S1-S4.
  assign wr_en = {rf_if.scr_sel, rf_if.reg_sel};

  function automatic logic [WIDTH-1:0] apply_fun(
    input fun_e             fun,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] din
  );
    logic [WIDTH-1:0] r;
    r = q;
    case (fun)
      FUN_DEC:   r = q - WIDTH'(1);   // wraps 0 -> all ones
      FUN_INC:   r = q + WIDTH'(1);   // wraps all ones -> 0
      FUN_LOAD:  r = din;
      FUN_CLEAR: r = '0;
      FUN_LDLZ:  r = WIDTH'(din[7:0]);
      FUN_LDL:   r = {q[WIDTH-1:8], din[7:0]};
      // Input low byte lands in the high byte; register low byte is kept.
      FUN_LDH:   r = (q & LOW_MASK) | (WIDTH'(din[7:0]) << 8);
      FUN_LDSX:  r = {{(WIDTH-8){din[7]}}, din[7:0]};
    endcase
    return r;
  endfunction

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      regs_d[k] = regs_q[k];
      if (wr_en[k]) begin
        regs_d[k] = apply_fun(fun_e'(rf_if.fun_sel), regs_q[k], rf_if.i_data);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 8; k++) begin
        regs_q[k] <= RESET_VALUE;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  // A 3-bit select indexes all 8 entries, so every code decodes.
  assign rf_if.out_a = regs_q[rf_if.out_a_sel];
  assign rf_if.out_b = regs_q[rf_if.out_b_sel];

endmodule

// File: tb/tb_general_register_file.sv
module tb_general_register_file;

  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  general_register_file_if #(.WIDTH(16)) rf_if ();

  general_register_file #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .rf_if (rf_if)
  );

  int model [8];
  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Next register value from the function table, in plain integer arithmetic.
  function automatic int next_val(input int fun, input int q, input int d);
    int lo;
    lo = d % 256;
    case (fun)
      0: return (q + 65535) % 65536;
      1: return (q + 1) % 65536;
      2: return d;
      3: return 0;
      4: return lo;
      5: return (q / 256) * 256 + lo;
      6: return lo * 256 + (q % 256);
      default: return (lo >= 128) ? (65280 + lo) : lo;
    endcase
  endfunction

  // Every falling edge: both read ports must show the modelled contents.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_out_a", rf_if.out_a, 16'(model[rf_if.out_a_sel]));
      chk("cmp_out_b", rf_if.out_b, 16'(model[rf_if.out_b_sel]));
    end
  end

  // One write cycle: drive controls, take the edge, advance the model.
  task automatic wr(input int fun, input logic [3:0] rs, input logic [3:0] ss, input logic [15:0] d);
    logic [7:0] en;
    rf_if.fun_sel = 3'(fun);
    rf_if.reg_sel = rs;
    rf_if.scr_sel = ss;
    rf_if.i_data  = d;
    en = {ss, rs};
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < 8; k++)
        if (en[k]) model[k] = next_val(fun, model[k], int'(d));
    end
    #1;
    rf_if.reg_sel = 4'h0;
    rf_if.scr_sel = 4'h0;
  endtask

  // Sweep both read ports over all eight registers during the low clock phase.
  task automatic check_all(input string name);
    logic [2:0] sa, sb;
    sa = rf_if.out_a_sel;
    sb = rf_if.out_b_sel;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rf_if.out_a_sel = 3'(k);
      rf_if.out_b_sel = 3'(7 - k);
      #1;
      chk({name, "_a"}, rf_if.out_a, 16'(model[k]));
      chk({name, "_b"}, rf_if.out_b, 16'(model[7 - k]));
    end
    rf_if.out_a_sel = sa;
    rf_if.out_b_sel = sb;
  endtask

  task automatic sel(input logic [2:0] a, input logic [2:0] b);
    rf_if.out_a_sel = a;
    rf_if.out_b_sel = b;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) model[k] = 0;
    rst = 1'b1;
    rf_if.fun_sel = 3'b010;
    rf_if.reg_sel = 4'hF;
    rf_if.scr_sel = 4'hF;
    rf_if.i_data  = 16'h1234;
    sel(3'd0, 3'd1);
    #1;
    cmp_en = 1'b1;
    chk("reset_out_a", rf_if.out_a, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_hold_a", rf_if.out_a, 16'h0000);
    chk("reset_hold_b", rf_if.out_b, 16'h0000);
    check_all("reset_all");

    @(negedge clk);
    rst = 1'b0;
    rf_if.reg_sel = 4'h0;
    rf_if.scr_sel = 4'h0;

    // LOAD R2, both ports on R2.
    sel(3'd1, 3'd1);
    wr(2, 4'b0010, 4'b0000, 16'hBEEF);
    chk("r2_load_a", rf_if.out_a, 16'hBEEF);
    chk("r2_load_b", rf_if.out_b, 16'hBEEF);
    check_all("after_r2");

    // Read-during-write: old value before the edge, new value after.
    rf_if.fun_sel = 3'b010;
    rf_if.reg_sel = 4'b0010;
    rf_if.i_data  = 16'h1111;
    #2;
    chk("rdw_before", rf_if.out_a, 16'hBEEF);
    wr(2, 4'b0010, 4'b0000, 16'h1111);
    chk("rdw_after", rf_if.out_a, 16'h1111);

    // S3 wrap-around.
    sel(3'd6, 3'd1);
    wr(2, 4'b0000, 4'b0100, 16'hFFFF);
    chk("s3_load", rf_if.out_a, 16'hFFFF);
    wr(1, 4'b0000, 4'b0100, 16'h0000);
    chk("s3_inc_wrap", rf_if.out_a, 16'h0000);
    wr(0, 4'b0000, 4'b0100, 16'h0000);
    chk("s3_dec_wrap", rf_if.out_a, 16'hFFFF);

    // R1 byte operations.
    sel(3'd0, 3'd6);
    wr(2, 4'b0001, 4'b0000, 16'hABCD);
    chk("r1_load", rf_if.out_a, 16'hABCD);
    wr(5, 4'b0001, 4'b0000, 16'h0012);
    chk("r1_ldl", rf_if.out_a, 16'hAB12);
    wr(6, 4'b0001, 4'b0000, 16'h0034);
    chk("r1_ldh", rf_if.out_a, 16'h3412);
    wr(4, 4'b0001, 4'b0000, 16'h0080);
    chk("r1_ldlz", rf_if.out_a, 16'h0080);
    wr(7, 4'b0001, 4'b0000, 16'h0080);
    chk("r1_ldsx", rf_if.out_a, 16'hFF80);
    wr(7, 4'b0001, 4'b0000, 16'hFF7F);
    chk("r1_ldsx_pos", rf_if.out_a, 16'h007F);
    check_all("after_bytes");

    // Multiple selected registers, each on its own value.
    wr(1, 4'b1011, 4'b0101, 16'h0000);
    check_all("multi_inc");
    wr(0, 4'b0110, 4'b1100, 16'h0000);
    check_all("multi_dec");

    // Broadcast load, then idle cycles with CLEAR but nothing selected.
    sel(3'd3, 3'd7);
    wr(2, 4'b1111, 4'b1111, 16'h5A5A);
    check_all("bcast");
    for (int n = 0; n < 3; n++) begin
      wr(3, 4'b0000, 4'b0000, 16'h0000);
      chk("idle_hold_a", rf_if.out_a, 16'h5A5A);
      chk("idle_hold_b", rf_if.out_b, 16'h5A5A);
    end
    check_all("idle_all");

    // CLEAR only R3 and S2.
    wr(3, 4'b0100, 4'b0010, 16'hFFFF);
    check_all("clear_some");

    // Async reset between edges; write on the edge during reset is ignored.
    sel(3'd3, 3'd3);
    wr(2, 4'b1000, 4'b0000, 16'h00FF);
    chk("r4_load", rf_if.out_a, 16'h00FF);
    @(negedge clk);
    #3;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) model[k] = 0;
    #1;
    chk("async_rst_a", rf_if.out_a, 16'h0000);
    wr(2, 4'b1000, 4'b0000, 16'h1234);
    chk("rst_write_ignored", rf_if.out_a, 16'h0000);
    check_all("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    wr(2, 4'b1000, 4'b0000, 16'h1234);
    chk("post_rst_write", rf_if.out_a, 16'h1234);
    check_all("post_rst");

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
